// File: rtl/ibex_pkg.sv
// Shared types and constants for the Ibex bus memory responder.
//   mem_rsp_entry_t   : one slot of the response pipeline {valid, err, rdata}
//   MEM_RSP_LFSR_SEED : reset value of the grant-stall LFSR
//   MEM_RSP_LFSR_TAPS : feedback mask for taps 16,14,13,11 (bits 15,13,12,10)
package ibex_pkg;

  typedef struct packed {
    logic        valid;
    logic        err;
    logic [31:0] rdata;
  } mem_rsp_entry_t;

  localparam logic [15:0] MEM_RSP_LFSR_SEED = 16'hACE1;
  localparam logic [15:0] MEM_RSP_LFSR_TAPS = 16'hB400;

endpackage

// File: rtl/ibex_mem_rsp_stall_lfsr.sv
// Pseudo-random grant-stall source for the memory responder.
// A 16-bit Fibonacci LFSR that advances every cycle from a fixed seed, so the
// stall pattern is reproducible from reset.
// Ports:
//   clk_i   : clock
//   rst_i   : asynchronous active-high reset (reloads the seed)
//   stall_o : high when the two low LFSR bits are both zero (~25% of cycles)
module ibex_mem_rsp_stall_lfsr
  import ibex_pkg::*;
(
  input  logic clk_i,
  input  logic rst_i,
  output logic stall_o
);

  logic [15:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = {lfsr_q[14:0], ^(lfsr_q & MEM_RSP_LFSR_TAPS)};
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      lfsr_q <= MEM_RSP_LFSR_SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign stall_o = (lfsr_q[1:0] == 2'b00);

endmodule

// File: rtl/ibex_mem_responder.sv
// Memory responder for the Ibex req/gnt/rvalid bus (instr or data side).
// Services at most one request per cycle from a word-organised array and returns
// in-order responses exactly RspLatency cycles after the grant.
// Out-of-range accesses respond with err_o=1, rdata_o=0 and leave the array alone.
// Optional feature: define IBEX_MEM_RSP_STALL_EN to withhold grants pseudo-randomly
// via an LFSR; without it grants are limited only by MaxOutstanding.
// Ports:
//   clk_i, rst_i         : clock, asynchronous active-high reset
//   req_i / gnt_o        : request valid / accepted this cycle
//   we_i, be_i           : write enable, byte enables
//   addr_i, wdata_i      : byte address (bits [1:0] ignored), write data
//   rvalid_o             : one-cycle response strobe
//   rdata_o, err_o       : read data and error flag, zero when rvalid_o is low
module ibex_mem_responder
  import ibex_pkg::*;
#(
  parameter int unsigned MemSizeBytes   = 65536,
  parameter logic [31:0] BaseAddr       = 32'h0010_0000,
  parameter int unsigned RspLatency     = 1,
  parameter int unsigned MaxOutstanding = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  output logic        gnt_o,
  input  logic        we_i,
  input  logic [3:0]  be_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic        err_o
);

  localparam int unsigned Words    = MemSizeBytes / 4;
  localparam int unsigned IdxW     = (Words > 1) ? $clog2(Words) : 1;
  localparam logic [31:0] MemSizeW = 32'(MemSizeBytes);
  localparam logic [2:0]  MaxOut   = 3'(MaxOutstanding);

  logic [31:0] mem [Words];

  logic [31:0]    offset;
  logic           in_range;
  logic [IdxW-1:0] idx;
  logic           stall;

  mem_rsp_entry_t pipe_q [RspLatency];
  mem_rsp_entry_t pipe_d [RspLatency];
  mem_rsp_entry_t new_entry;

  logic [2:0] outstanding_q, outstanding_d;
  logic [2:0] outstanding_eff;
  logic       rsp_valid;

  // Wrapping subtract: addresses below BaseAddr become huge and fail the compare.
  assign offset   = addr_i - BaseAddr;
  assign in_range = (offset < MemSizeW);
  assign idx      = offset[IdxW+1:2];

  logic unused_offset_bits;
  assign unused_offset_bits = ^{offset[31:IdxW+2], offset[1:0]};

`ifdef IBEX_MEM_RSP_STALL_EN
  ibex_mem_rsp_stall_lfsr u_stall_lfsr (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .stall_o (stall)
  );
`else
  assign stall = 1'b0;
`endif

  assign rsp_valid = pipe_q[0].valid;

  // A response leaving this cycle frees its slot, so grant can re-assert in the
  // same cycle as that rvalid.
  assign outstanding_eff = outstanding_q - {2'b00, rsp_valid};
  assign gnt_o           = req_i && (outstanding_eff < MaxOut) && !stall;

  always_comb begin
    new_entry = '0;
    if (gnt_o) begin
      new_entry.valid = 1'b1;
      new_entry.err   = !in_range;
      if (in_range && !we_i) begin
        new_entry.rdata = mem[idx];
      end
    end
  end

  // Entries enter at the tail and reach slot 0 RspLatency cycles after grant.
  always_comb begin
    for (int unsigned i = 0; i + 1 < RspLatency; i++) begin
      pipe_d[i] = pipe_q[i+1];
    end
    pipe_d[RspLatency-1] = new_entry;
  end

  always_comb begin
    outstanding_d = outstanding_q + {2'b00, gnt_o} - {2'b00, rsp_valid};
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      outstanding_q <= 3'd0;
      for (int unsigned i = 0; i < RspLatency; i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      outstanding_q <= outstanding_d;
      for (int unsigned i = 0; i < RspLatency; i++) begin
        pipe_q[i] <= pipe_d[i];
      end
    end
  end

  // Array contents deliberately survive reset.
  always_ff @(posedge clk_i) begin
    if (gnt_o && we_i && in_range) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (be_i[b]) begin
          mem[idx][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end
    end
  end

  assign rvalid_o = rsp_valid;
  assign rdata_o  = rsp_valid ? pipe_q[0].rdata : 32'h0;
  assign err_o    = rsp_valid ? pipe_q[0].err   : 1'b0;

endmodule

// File: tb/tb_ibex_mem_responder.sv
// Bench for ibex_mem_responder: a queue-based transaction model predicts every
// cycle's gnt/rvalid/rdata/err; directed cases pin the model with literal values.
module tb_ibex_mem_responder;

  localparam int unsigned MEM_BYTES = 1024;
  localparam int unsigned WORDS     = MEM_BYTES / 4;
  localparam logic [31:0] BASE      = 32'h0010_0000;
  localparam int unsigned RSP_LAT   = 3;
  localparam int unsigned MAX_OUT   = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic        we  = 1'b0;
  logic [3:0]  be  = 4'h0;
  logic [31:0] addr  = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic        gnt, rvalid, err;
  logic [31:0] rdata;

  always #5 clk = ~clk;

  ibex_mem_responder #(
    .MemSizeBytes   (MEM_BYTES),
    .BaseAddr       (BASE),
    .RspLatency     (RSP_LAT),
    .MaxOutstanding (MAX_OUT)
  ) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .req_i    (req),
    .gnt_o    (gnt),
    .we_i     (we),
    .be_i     (be),
    .addr_i   (addr),
    .wdata_i  (wdata),
    .rvalid_o (rvalid),
    .rdata_o  (rdata),
    .err_o    (err)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {int due; logic [31:0] rdata; logic err;} exp_t;
  typedef struct {int cyc; logic [31:0] rdata; logic err;} rsp_t;

  exp_t        expq[$];
  rsp_t        rsp_log[$];
  int          gnt_log[$];
  logic [31:0] model_mem [WORDS];

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endfunction

  // Transaction-level model: outstanding = queue length, response due = grant + latency.
  always @(negedge clk) begin : monitor
    logic        exp_v, allowed, accepted;
    logic [31:0] off;
    exp_t        e;
    if (rst) begin
      expq.delete();
      chk("rst_rvalid", {31'b0, rvalid}, 32'd0);
      chk("rst_gnt", {31'b0, gnt}, {31'b0, req});
    end else begin
      exp_v = (expq.size() != 0) && (expq[0].due == cyc);
      chk("rvalid", {31'b0, rvalid}, {31'b0, exp_v});
      if (rvalid) rsp_log.push_back('{cyc, rdata, err});
      if (exp_v) begin
        chk("rdata", rdata, expq[0].rdata);
        chk("err", {31'b0, err}, {31'b0, expq[0].err});
        void'(expq.pop_front());
      end else begin
        chk("idle_rdata", rdata, 32'h0);
        chk("idle_err", {31'b0, err}, 32'd0);
      end
      allowed = req && (expq.size() < int'(MAX_OUT));
`ifdef IBEX_MEM_RSP_STALL_EN
      if (gnt && !allowed) chk("gnt_illegal", {31'b0, gnt}, 32'd0);
      accepted = gnt;
`else
      chk("gnt", {31'b0, gnt}, {31'b0, allowed});
      accepted = allowed;
`endif
      if (accepted) begin
        off   = addr - BASE;
        e.due = cyc + int'(RSP_LAT);
        if (off < MEM_BYTES) begin
          e.err = 1'b0;
          if (we) begin
            for (int b = 0; b < 4; b++)
              if (be[b]) model_mem[int'(off >> 2)][8*b +: 8] = wdata[8*b +: 8];
            e.rdata = 32'h0;
          end else begin
            e.rdata = model_mem[int'(off >> 2)];
          end
        end else begin
          e.err   = 1'b1;
          e.rdata = 32'h0;
        end
        expq.push_back(e);
        gnt_log.push_back(cyc);
      end
      chk("outstanding_max", {31'b0, (dut.outstanding_q <= 3'(MAX_OUT))}, 32'd1);
    end
    cyc++;
  end

  task automatic do_req(input logic w, input logic [31:0] a, input logic [3:0] b,
                        input logic [31:0] d);
    req = 1'b1; we = w; addr = a; be = b; wdata = d;
    for (int n = 0; ; n++) begin
      @(negedge clk);
      if (gnt) break;
      if (n == 100) begin
        total++; bad++;
        $display("FAIL grant_timeout addr=%h got no gnt expected gnt within 100", a);
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic drain();
    req = 1'b0; we = 1'b0;
    repeat (RSP_LAT + 2) @(posedge clk);
    #1;
  endtask

  task automatic read_expect(input string name, input logic [31:0] a,
                             input logic [31:0] d, input logic e);
    drain();
    rsp_log.delete(); gnt_log.delete();
    do_req(1'b0, a, 4'h0, 32'h0);
    drain();
    chk({name, "_count"}, rsp_log.size(), 32'd1);
    if (rsp_log.size() == 1 && gnt_log.size() == 1) begin
      chk({name, "_data"}, rsp_log[0].rdata, d);
      chk({name, "_err"}, {31'b0, rsp_log[0].err}, {31'b0, e});
      chk({name, "_lat"}, rsp_log[0].cyc - gnt_log[0], RSP_LAT);
    end
  endtask

`ifdef IBEX_MEM_RSP_STALL_EN
  logic        rst_s = 1'b1, req_s = 1'b0, s_active = 1'b0, prev_gnt_s = 1'b0;
  logic        gnt_s, rvalid_s, err_s;
  logic [31:0] rdata_s;
  int          s_grants = 0;

  ibex_mem_responder #(
    .MemSizeBytes   (MEM_BYTES),
    .BaseAddr       (BASE),
    .RspLatency     (1),
    .MaxOutstanding (2)
  ) dut_s (
    .clk_i    (clk),
    .rst_i    (rst_s),
    .req_i    (req_s),
    .gnt_o    (gnt_s),
    .we_i     (1'b0),
    .be_i     (4'h0),
    .addr_i   (BASE),
    .wdata_i  (32'h0),
    .rvalid_o (rvalid_s),
    .rdata_o  (rdata_s),
    .err_o    (err_s)
  );

  always @(negedge clk) begin
    if (s_active) begin
      chk("stall_rsp_lat", {31'b0, rvalid_s}, {31'b0, prev_gnt_s});
      prev_gnt_s = gnt_s;
      if (gnt_s) s_grants++;
    end
  end
`endif

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset_rvalid", {31'b0, rvalid}, 32'd0);
    chk("reset_rdata", rdata, 32'h0);
    chk("reset_err", {31'b0, err}, 32'd0);
    chk("reset_gnt", {31'b0, gnt}, 32'd0);
    chk("reset_outstanding", {29'b0, dut.outstanding_q}, 32'd0);
    rst = 1'b0;
`ifdef IBEX_MEM_RSP_STALL_EN
    rst_s = 1'b0;
`endif
    @(posedge clk); #1;

    // Fill the array so every later read has a known expected value.
    for (int w = 0; w < int'(WORDS); w++) do_req(1'b1, BASE + 4 * w, 4'hF, $urandom);
    drain();

    // Write then read in the next cycle.
    rsp_log.delete(); gnt_log.delete();
    do_req(1'b1, BASE + 8, 4'hF, 32'hDEADBEEF);
    do_req(1'b0, BASE + 8, 4'h0, 32'h0);
    drain();
    chk("wr_rd_count", rsp_log.size(), 32'd2);
    if (rsp_log.size() == 2 && gnt_log.size() == 2) begin
      chk("wr_rd_data", rsp_log[1].rdata, 32'hDEADBEEF);
      chk("wr_rd_err", {31'b0, rsp_log[1].err}, 32'd0);
      chk("wr_rd_lat", rsp_log[1].cyc - gnt_log[1], 32'd3);
    end

    // Byte enables.
    do_req(1'b1, BASE + 16, 4'hF, 32'h11223344);
    do_req(1'b1, BASE + 16, 4'b0101, 32'hAABBCCDD);
    read_expect("byte_en", BASE + 16, 32'h11BB33DD, 1'b0);
    do_req(1'b1, BASE + 16, 4'h0, 32'hFFFFFFFF);
    read_expect("be_zero", BASE + 16, 32'h11BB33DD, 1'b0);

    // Out of range, including an address that would alias word 2 if undecoded.
    read_expect("oor_top", BASE + MEM_BYTES, 32'h0, 1'b1);
    read_expect("oor_below", BASE - 4, 32'h0, 1'b1);
    do_req(1'b1, BASE + MEM_BYTES, 4'hF, 32'hFFFFFFFF);
    do_req(1'b1, BASE - 4, 4'hF, 32'hFFFFFFFF);
    do_req(1'b1, BASE + MEM_BYTES + 8, 4'hF, 32'h0BAD0BAD);
    for (int w = 0; w < int'(WORDS); w++) do_req(1'b0, BASE + 4 * w, 4'h0, 32'h0);
    read_expect("oor_untouched", BASE + 8, 32'hDEADBEEF, 1'b0);

`ifndef IBEX_MEM_RSP_STALL_EN
    // Outstanding limit: grants at T0, T1, stall at T2, re-grant with rvalid at T3.
    drain();
    gnt_log.delete();
    for (int i = 0; i < 4; i++) do_req(1'b0, BASE + 4 * i, 4'h0, 32'h0);
    drain();
    chk("limit_count", gnt_log.size(), 32'd4);
    if (gnt_log.size() == 4) begin
      chk("limit_t1", gnt_log[1] - gnt_log[0], 32'd1);
      chk("limit_t3", gnt_log[2] - gnt_log[0], 32'd3);
      chk("limit_t4", gnt_log[3] - gnt_log[0], 32'd4);
    end
`endif

    // Reset with two reads in flight.
    drain();
    do_req(1'b0, BASE + 8, 4'h0, 32'h0);
    do_req(1'b0, BASE + 12, 4'h0, 32'h0);
    req = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    rsp_log.delete();
    repeat (8) @(posedge clk);
    #1;
    chk("rst_no_rsp", rsp_log.size(), 32'd0);
    chk("rst_outstanding", {29'b0, dut.outstanding_q}, 32'd0);
    read_expect("retained", BASE + 8, 32'hDEADBEEF, 1'b0);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      logic [31:0] a;
      if ($urandom_range(0, 3) == 0) begin
        req = 1'b0;
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
      if ($urandom_range(0, 9) != 0) begin
        a = BASE + 4 * $urandom_range(0, WORDS - 1) + $urandom_range(0, 3);
      end else begin
        case ($urandom_range(0, 2))
          0:       a = BASE + MEM_BYTES + 4 * $urandom_range(0, WORDS - 1);
          1:       a = BASE - 4 - 4 * $urandom_range(0, WORDS - 1);
          default: a = $urandom;
        endcase
      end
      do_req($urandom_range(0, 1) == 1, a, 4'($urandom), $urandom);
    end
    drain();

`ifdef IBEX_MEM_RSP_STALL_EN
    req_s = 1'b1;
    s_active = 1'b1;
    repeat (1000) @(posedge clk);
    #1;
    s_active = 1'b0;
    req_s = 1'b0;
    chk("stall_grant_range", {31'b0, (s_grants >= 700 && s_grants <= 800)}, 32'd1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
